// File: rtl/ospi_flash_ctrl.sv
// Octal-SPI flash host sequencer: turns single-byte read/write/erase requests
// into CS/CLK/IO frames, prefixing write and erase with a WREN frame.
module ospi_flash_ctrl #(
  parameter int          CLK_DIV       = 2,
  parameter int          ADDR_BYTES    = 3,
  parameter int          DUMMY_CYCLES  = 4,
  parameter int          CS_GAP_CYCLES = 2,
  parameter logic [7:0]  OP_READ       = 8'h0B,
  parameter logic [7:0]  OP_WRITE      = 8'h02,
  parameter logic [7:0]  OP_ERASE      = 8'h20,
  parameter logic [7:0]  OP_WREN       = 8'h06
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    req_valid,
  output logic                    req_ready,
  input  logic [1:0]              req_op,
  input  logic [8*ADDR_BYTES-1:0] req_addr,
  input  logic [7:0]              req_wdata,
  output logic                    resp_valid,
  output logic [7:0]              resp_rdata,
  output logic                    resp_err,
  output logic                    busy,
  output logic                    OSPI_CLK,
  output logic                    OSPI_CS,
  output logic [7:0]              OSPI_IO_OUT,
  output logic                    OSPI_IO_OE,
  input  logic [7:0]              OSPI_IO_IN
);
  localparam int AW = 8 * ADDR_BYTES;
  localparam int CW = (CLK_DIV > 1) ? $clog2(2 * CLK_DIV) : 1;

  typedef enum logic [3:0] {
    S_IDLE, S_WREN_SETUP, S_WREN_CMD, S_WREN_HOLD, S_GAP, S_SETUP,
    S_CMD, S_ADDR, S_DUMMY, S_DATA, S_HOLD, S_DONE
  } state_t;

  state_t          r_state;
  logic [CW-1:0]   r_cnt;
  logic [7:0]      r_idx;
  logic [1:0]      r_op;
  logic [AW-1:0]   r_addr;
  logic [7:0]      r_wdata;
  logic            r_cs, r_sclk, r_oe, r_rvalid, r_err;
  logic [7:0]      r_io, r_rdata;

  logic            w_beat, w_end, w_rise;
  logic [7:0]      w_opcode;

  assign w_beat   = (r_state == S_WREN_CMD) || (r_state == S_CMD) || (r_state == S_ADDR) ||
                    (r_state == S_DUMMY) || (r_state == S_DATA);
  assign w_end    = (r_cnt == CW'(2 * CLK_DIV - 1));
  assign w_rise   = (r_cnt == CW'(CLK_DIV - 1));
  assign w_opcode = (r_op == 2'd0) ? OP_READ : (r_op == 2'd1) ? OP_WRITE : OP_ERASE;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state  <= S_IDLE;
      r_cnt    <= '0;
      r_idx    <= '0;
      r_op     <= '0;
      r_addr   <= '0;
      r_wdata  <= '0;
      r_cs     <= 1'b1;
      r_sclk   <= 1'b0;
      r_oe     <= 1'b0;
      r_io     <= '0;
      r_rvalid <= 1'b0;
      r_err    <= 1'b0;
      r_rdata  <= '0;
    end else begin
      r_rvalid <= 1'b0;
      r_err    <= 1'b0;
      // Serial clock is low for the first half of each beat, high for the second.
      if (w_beat) begin
        r_cnt  <= w_end ? '0 : r_cnt + 1'b1;
        r_sclk <= !w_end && (r_sclk || w_rise);
      end else begin
        r_cnt  <= '0;
        r_sclk <= 1'b0;
      end
      case (r_state)
        S_IDLE: if (req_valid) begin
          r_op    <= req_op;
          r_addr  <= req_addr;
          r_wdata <= req_wdata;
          case (req_op)
            2'd0:    begin r_state <= S_SETUP; r_cs <= 1'b0; end
            2'd3:    begin r_state <= S_DONE; r_rvalid <= 1'b1; r_err <= 1'b1; end
            default: begin r_state <= S_WREN_SETUP; r_cs <= 1'b0; end
          endcase
        end
        S_WREN_SETUP: begin r_state <= S_WREN_CMD; r_io <= OP_WREN; r_oe <= 1'b1; end
        S_WREN_CMD: if (w_end) begin r_state <= S_WREN_HOLD; r_io <= '0; r_oe <= 1'b0; end
        S_WREN_HOLD: begin
          r_idx <= '0;
          if (CS_GAP_CYCLES > 0) begin r_state <= S_GAP; r_cs <= 1'b1; end
          else r_state <= S_SETUP;
        end
        S_GAP: if (r_idx == 8'(CS_GAP_CYCLES - 1)) begin
          r_state <= S_SETUP; r_cs <= 1'b0; r_idx <= '0;
        end else r_idx <= r_idx + 1'b1;
        S_SETUP: begin r_state <= S_CMD; r_io <= w_opcode; r_oe <= 1'b1; end
        // Address goes out MSB byte first by shifting the latched copy left.
        S_CMD: if (w_end) begin
          r_state <= S_ADDR; r_io <= r_addr[AW-1 -: 8]; r_addr <= r_addr << 8; r_idx <= '0;
        end
        S_ADDR: if (w_end) begin
          if (r_idx == 8'(ADDR_BYTES - 1)) begin
            r_idx <= '0;
            r_io  <= '0;
            r_oe  <= 1'b0;
            if (r_op == 2'd0) r_state <= (DUMMY_CYCLES > 0) ? S_DUMMY : S_DATA;
            else if (r_op == 2'd1) begin r_state <= S_DATA; r_io <= r_wdata; r_oe <= 1'b1; end
            else r_state <= S_HOLD;
          end else begin
            r_idx <= r_idx + 1'b1; r_io <= r_addr[AW-1 -: 8]; r_addr <= r_addr << 8;
          end
        end
        S_DUMMY: if (w_end) begin
          if (r_idx == 8'(DUMMY_CYCLES - 1)) begin r_state <= S_DATA; r_idx <= '0; end
          else r_idx <= r_idx + 1'b1;
        end
        S_DATA: begin
          if (w_rise && r_op == 2'd0) r_rdata <= OSPI_IO_IN;
          if (w_end) begin r_state <= S_HOLD; r_io <= '0; r_oe <= 1'b0; end
        end
        S_HOLD: begin r_state <= S_DONE; r_cs <= 1'b1; r_rvalid <= 1'b1; end
        S_DONE: r_state <= S_IDLE;
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign req_ready   = (r_state == S_IDLE);
  assign busy        = (r_state != S_IDLE);
  assign resp_valid  = r_rvalid;
  assign resp_err    = r_err;
  assign resp_rdata  = r_rdata;
  assign OSPI_CLK    = r_sclk;
  assign OSPI_CS     = r_cs;
  assign OSPI_IO_OUT = r_io;
  assign OSPI_IO_OE  = r_oe;
endmodule

// File: tb/tb_ospi_flash_ctrl.sv
// Bench for ospi_flash_ctrl: directed and random requests checked against a
// frame-level model (expected beat list, frame count, CS gap and latency).
module tb_ospi_flash_ctrl;
  localparam int CD = 2, AB = 3, DM = 4, GP = 2;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        reset = 1'b1, req_valid = 1'b0, req_ready, resp_valid, resp_err, busy;
  logic [1:0]  req_op = '0;
  logic [23:0] req_addr = '0;
  logic [7:0]  req_wdata = '0, resp_rdata, io_out, io_in, rd_val = 8'h00;
  logic        sclk, cs, oe;

  ospi_flash_ctrl #(.CLK_DIV(CD), .ADDR_BYTES(AB), .DUMMY_CYCLES(DM), .CS_GAP_CYCLES(GP)) dut (
    .clk(clk), .reset(reset), .req_valid(req_valid), .req_ready(req_ready), .req_op(req_op),
    .req_addr(req_addr), .req_wdata(req_wdata), .resp_valid(resp_valid), .resp_rdata(resp_rdata),
    .resp_err(resp_err), .busy(busy), .OSPI_CLK(sclk), .OSPI_CS(cs), .OSPI_IO_OUT(io_out),
    .OSPI_IO_OE(oe), .OSPI_IO_IN(io_in));

  // Second instance: fastest serial clock, no dummy beats.
  logic        rst1 = 1'b1, rv1 = 1'b0, rdy1, rsp1, err1, busy1, sclk1, cs1, oe1;
  logic [1:0]  op1 = '0;
  logic [23:0] addr1 = '0;
  logic [7:0]  wd1 = '0, rdata1, out1, in1 = 8'h00;

  ospi_flash_ctrl #(.CLK_DIV(1), .ADDR_BYTES(3), .DUMMY_CYCLES(0), .CS_GAP_CYCLES(2)) u1 (
    .clk(clk), .reset(rst1), .req_valid(rv1), .req_ready(rdy1), .req_op(op1),
    .req_addr(addr1), .req_wdata(wd1), .resp_valid(rsp1), .resp_rdata(rdata1),
    .resp_err(err1), .busy(busy1), .OSPI_CLK(sclk1), .OSPI_CS(cs1), .OSPI_IO_OUT(out1),
    .OSPI_IO_OE(oe1), .OSPI_IO_IN(in1));

  int checks = 0, failures = 0;

  // Flash-side model: record every beat at the serial clock rise.
  int n_rises = 0, frames = 0;
  logic [8:0] beats[$];
  always @(posedge sclk or negedge cs) begin
    if (sclk) begin
      n_rises = n_rises + 1;
      beats.push_back({oe, io_out});
    end else begin
      n_rises = 0;
      frames  = frames + 1;
    end
  end

  // Read data is valid only in the low half of the data beat; wrong value elsewhere.
  always_comb io_in = (n_rises == 1 + AB + DM) ? rd_val : ~rd_val;

  int viol = 0, gapc = 0;
  always @(negedge clk) begin
    if (oe === 1'b0 && io_out !== 8'h00) viol = viol + 1;
    if (cs === 1'b1 && sclk !== 1'b0) viol = viol + 1;
    if (busy === 1'b1 && cs === 1'b1 && resp_valid === 1'b0) gapc = gapc + 1;
  end

  int tog1 = 0;
  logic prev1 = 1'b0;
  always @(negedge clk) begin
    if (sclk1 !== prev1) tog1 = tog1 + 1;
    prev1 = sclk1;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  int beat_base, frame_base, gap_base, viol_base;
  logic [7:0] exp_rdata = 8'h00;

  task automatic accept(output int waited);
    beat_base = beats.size(); frame_base = frames; gap_base = gapc; viol_base = viol;
    waited = 0;
    while (!req_ready && waited < 100) begin @(negedge clk); waited++; end
    @(posedge clk); #1;
  endtask

  task automatic check_resp(input logic [1:0] op, input logic [23:0] addr, input logic [7:0] wd,
                            input logic [7:0] rd);
    logic [8:0] q[$];
    int lat, cyc, nfr, ngap;
    bit got, ok;
    case (op)
      2'd0:    lat = 3 + 2*CD*(2 + AB + DM);
      2'd1:    lat = 5 + GP + 2*CD*(3 + AB);
      2'd2:    lat = 5 + GP + 2*CD*(2 + AB);
      default: lat = 1;
    endcase
    nfr  = (op == 2'd0) ? 1 : (op == 2'd3) ? 0 : 2;
    ngap = (op == 2'd1 || op == 2'd2) ? GP : 0;
    if (op == 2'd1 || op == 2'd2) q.push_back({1'b1, 8'h06});
    if (op != 2'd3) begin
      q.push_back({1'b1, (op == 2'd0) ? 8'h0B : (op == 2'd1) ? 8'h02 : 8'h20});
      for (int i = 0; i < AB; i++) q.push_back({1'b1, 8'(addr >> (8*(AB-1-i)))});
    end
    if (op == 2'd0) for (int i = 0; i <= DM; i++) q.push_back(9'h000);
    if (op == 2'd1) q.push_back({1'b1, wd});
    if (op == 2'd0) exp_rdata = rd;

    cyc = 0; got = 0;
    while (!got && cyc < 200) begin @(negedge clk); cyc++; if (resp_valid) got = 1; end
    chk($sformatf("latency op%0d", op), cyc, lat);
    chk("resp_err", resp_err, (op == 2'd3));
    chk("resp_rdata", resp_rdata, exp_rdata);
    chk("done ready/busy", {req_ready, busy}, 2'b01);
    chk("frames", frames - frame_base, nfr);
    chk("cs gap", gapc - gap_base, ngap);
    chk("oe/clk idle rules", viol - viol_base, 0);
    ok = (beats.size() - beat_base == q.size());
    for (int i = 0; ok && i < q.size(); i++) if (beats[beat_base + i] !== q[i]) ok = 0;
    if (!ok) $display("beats got=%0d want=%0d", beats.size() - beat_base, q.size());
    chk($sformatf("beat list op%0d", op), ok, 1);
    @(negedge clk);
    chk("back to idle", {resp_valid, req_ready, busy}, 3'b010);
  endtask

  task automatic do_txn(input logic [1:0] op, input logic [23:0] addr, input logic [7:0] wd,
                        input logic [7:0] rd);
    int w;
    req_valid = 1; req_op = op; req_addr = addr; req_wdata = wd; rd_val = rd;
    accept(w);
    req_valid = 0; req_op = 2'($urandom); req_addr = 24'($urandom); req_wdata = 8'($urandom);
    check_resp(op, addr, wd, rd);
  endtask

  initial begin
    int w, cyc;
    bit seen;
    repeat (3) @(negedge clk);
    chk("reset outs", {req_ready, busy, resp_valid, resp_err, sclk, cs, oe}, 7'b1000010);
    chk("reset io/rdata", {io_out, resp_rdata}, 16'h0000);
    reset = 0; rst1 = 0;
    @(negedge clk);

    // Reset in the middle of a read's address phase.
    req_valid = 1; req_op = 2'd0; req_addr = 24'hABCDEF; rd_val = 8'h11;
    accept(w);
    req_valid = 0;
    repeat (8) @(negedge clk);
    chk("mid-addr cs/oe", {cs, oe}, 2'b01);
    reset = 1;
    @(negedge clk);
    chk("rst mid-frame", {cs, oe, sclk, busy, resp_valid, req_ready}, 6'b100001);
    reset = 0;
    seen = 0;
    repeat (5) begin @(negedge clk); if (resp_valid) seen = 1; end
    chk("no resp after reset", seen, 0);
    exp_rdata = 8'h00;

    do_txn(2'd0, 24'h123456, 8'h00, 8'hA5);
    do_txn(2'd1, 24'h000010, 8'h3C, 8'h77);
    do_txn(2'd2, 24'hFF0000, 8'h00, 8'h99);

    // Illegal op, then a read held valid is taken the cycle after DONE.
    req_valid = 1; req_op = 2'd3; req_addr = 24'h0; req_wdata = 8'h0;
    accept(w);
    req_op = 2'd0; req_addr = 24'h00F00D; rd_val = 8'h5E;
    check_resp(2'd3, 24'h0, 8'h0, 8'h0);
    accept(w);
    chk("b2b accept wait", w, 0);
    req_valid = 0;
    check_resp(2'd0, 24'h00F00D, 8'h00, 8'h5E);

    repeat (12) do_txn(2'($urandom_range(0, 3)), 24'($urandom), 8'($urandom), 8'($urandom));

    // Fast instance: CLK_DIV=1, no dummy beats.
    rv1 = 1; op1 = 2'd0; addr1 = 24'($urandom); in1 = 8'hC3;
    w = 0;
    while (!rdy1 && w < 50) begin @(negedge clk); w++; end
    @(posedge clk); #1;
    rv1 = 0;
    w = tog1; cyc = 0; seen = 0;
    while (!seen && cyc < 100) begin @(negedge clk); cyc++; if (rsp1) seen = 1; end
    chk("fast latency", cyc, 13);
    chk("fast rdata", rdata1, 8'hC3);
    chk("fast clk toggles", tog1 - w, 10);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog expired observed=running expected=finished");
    $fatal(1);
  end
endmodule
